// File: rtl/bomb_sequencer_if.sv
// rtl/bomb_sequencer_if.sv - link between the game sequencer and the countdown digit datapath
//
// Purpose: carries the countdown command/tick from the sequencer and the three
//          BCD digits back from the countdown.
// Signals:
//   switch_op   : 8'h10 for one cycle = start countdown, else 8'h00
//   sec_timer   : one-cycle tick strobe to the countdown
//   digit_three : hundreds digit (BCD) from the countdown
//   digit_two   : tens digit (BCD) from the countdown
//   digit_one   : ones digit (BCD) from the countdown
interface bomb_sequencer_if;
    logic [7:0] switch_op;
    logic       sec_timer;
    logic [3:0] digit_three;
    logic [3:0] digit_two;
    logic [3:0] digit_one;

    modport master (
        output switch_op,
        output sec_timer,
        input  digit_three,
        input  digit_two,
        input  digit_one
    );

    modport slave (
        input  switch_op,
        input  sec_timer,
        output digit_three,
        output digit_two,
        output digit_one
    );
endinterface

// File: rtl/bomb_sequencer.sv
// rtl/bomb_sequencer.sv - game controller that arms the countdown, ticks it and judges defuse/explode
//
// Purpose: conditions the arm button and wire loops, runs the IDLE/ARMING/ACTIVE/
//          DEFUSED/EXPLODED game FSM, generates the strike-scaled second tick and
//          decides the outcome.
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous active-low reset, clears all state
//   arm_btn   : debounced arm button (asynchronous, active-high)
//   wires     : wire loop inputs (asynchronous, 1 = intact, 0 = cut)
//   key_code  : wires that must be cut to defuse, latched at arm
//   cd        : countdown link (switch_op, sec_timer out; digits in)
//   strikes   : current strike count
//   state_out : FSM state encoding
//   defused   : high while in DEFUSED
//   exploded  : high while in EXPLODED
module bomb_sequencer #(
    parameter int TICK_DIV    = 50000000,
    parameter int MAX_STRIKES = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arm_btn,
    input  logic [3:0]              wires,
    input  logic [3:0]              key_code,
    bomb_sequencer_if.master        cd,
    output logic [1:0]              strikes,
    output logic [2:0]              state_out,
    output logic                    defused,
    output logic                    exploded
);

    localparam int          CW      = $clog2(TICK_DIV);
    localparam logic [31:0] DIV     = 32'(TICK_DIV);
    localparam logic [1:0]  MAX_STR = 2'(MAX_STRIKES);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMING   = 3'd1,
        S_ACTIVE   = 3'd2,
        S_DEFUSED  = 3'd3,
        S_EXPLODED = 3'd4
    } state_t;

    state_t state, state_nxt;

    // input conditioning: two synchronizer flops plus an edge register
    logic       arm_s1, arm_s2, arm_prev;
    logic [3:0] wires_s1, wires_s2, wires_prev;

    logic [3:0]    code, code_nxt;
    logic [3:0]    mask, mask_nxt;
    logic [1:0]    strikes_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [7:0]    switch_op_r, switch_op_nxt;
    logic          sec_timer_r, sec_timer_nxt;
    logic          defused_nxt, exploded_nxt;

    logic          arm_rise;
    logic [3:0]    cut;
    logic          wires_whole;
    logic [31:0]   period_last;
    logic          tick_hit;
    logic          digits_zero;
    logic          wrong_cut;
    logic [1:0]    strikes_inc;
    logic [3:0]    mask_upd;
    logic          boom;
    logic          win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arm_s1     <= 1'b0;
            arm_s2     <= 1'b0;
            arm_prev   <= 1'b0;
            wires_s1   <= 4'hF;
            wires_s2   <= 4'hF;
            wires_prev <= 4'hF;
        end else begin
            arm_s1     <= arm_btn;
            arm_s2     <= arm_s1;
            arm_prev   <= arm_s2;
            wires_s1   <= wires;
            wires_s2   <= wires_s1;
            wires_prev <= wires_s2;
        end
    end

    assign arm_rise    = arm_s2 & ~arm_prev;
    assign cut         = wires_prev & ~wires_s2;
    assign wires_whole = (wires_s2 == 4'hF);

    // the tick period halves with each strike; a strike only changes the compare
    // target, so an overshooting count runs on to the full-period wrap once
    assign period_last = (DIV >> strikes) - 32'd1;
    assign tick_hit    = (32'(count) == period_last);
    assign digits_zero = (cd.digit_three == 4'd0) && (cd.digit_two == 4'd0)
                      && (cd.digit_one == 4'd0);

    // any number of wrong wires cut in one cycle costs a single strike
    assign wrong_cut   = |(cut & ~code);
    assign strikes_inc = (wrong_cut && (strikes != MAX_STR)) ? strikes + 2'd1 : strikes;
    assign mask_upd    = mask | (cut & code);
    assign boom        = (strikes_inc == MAX_STR) || (tick_hit && digits_zero);
    assign win         = (mask_upd == code);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            code        <= 4'h0;
            mask        <= 4'h0;
            strikes     <= 2'd0;
            count       <= '0;
            switch_op_r <= 8'h00;
            sec_timer_r <= 1'b0;
            defused     <= 1'b0;
            exploded    <= 1'b0;
        end else begin
            state       <= state_nxt;
            code        <= code_nxt;
            mask        <= mask_nxt;
            strikes     <= strikes_nxt;
            count       <= count_nxt;
            switch_op_r <= switch_op_nxt;
            sec_timer_r <= sec_timer_nxt;
            defused     <= defused_nxt;
            exploded    <= exploded_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        code_nxt      = code;
        mask_nxt      = mask;
        strikes_nxt   = strikes;
        count_nxt     = count;
        switch_op_nxt = 8'h00;
        sec_timer_nxt = 1'b0;
        defused_nxt   = defused;
        exploded_nxt  = exploded;

        case (state)
            S_IDLE: begin
                if (arm_rise && wires_whole && (key_code != 4'h0)) begin
                    code_nxt      = key_code;
                    mask_nxt      = 4'h0;
                    strikes_nxt   = 2'd0;
                    switch_op_nxt = 8'h10;
                    state_nxt     = S_ARMING;
                end
            end
            S_ARMING: begin
                count_nxt = '0;
                state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                mask_nxt    = mask_upd;
                strikes_nxt = strikes_inc;
                if (tick_hit || (32'(count) == DIV - 32'd1)) begin
                    count_nxt = '0;
                end else begin
                    count_nxt = count + CW'(1);
                end
                // explode outranks defuse, and either outcome swallows the tick
                if (boom) begin
                    exploded_nxt = 1'b1;
                    state_nxt    = S_EXPLODED;
                end else if (win) begin
                    defused_nxt = 1'b1;
                    state_nxt   = S_DEFUSED;
                end else begin
                    sec_timer_nxt = tick_hit;
                end
            end
            S_DEFUSED, S_EXPLODED: begin
                if (arm_rise && wires_whole) begin
                    strikes_nxt  = 2'd0;
                    mask_nxt     = 4'h0;
                    defused_nxt  = 1'b0;
                    exploded_nxt = 1'b0;
                    state_nxt    = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign cd.switch_op = switch_op_r;
    assign cd.sec_timer = sec_timer_r;
    assign state_out    = state;

endmodule

// File: tb/tb_bomb_sequencer.sv
// tb/tb_bomb_sequencer.sv - self-checking bench for bomb_sequencer against a game-rule model
module tb_bomb_sequencer;
    localparam int TICK_DIV    = 8;
    localparam int MAX_STRIKES = 3;

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       arm_btn  = 1'b0;
    logic [3:0] wires    = 4'hF;
    logic [3:0] key_code = 4'h0;
    logic [1:0] strikes;
    logic [2:0] state_out;
    logic       defused;
    logic       exploded;

    bomb_sequencer_if cd();

    bomb_sequencer #(.TICK_DIV(TICK_DIV), .MAX_STRIKES(MAX_STRIKES)) dut (
        .clk(clk), .reset(reset), .arm_btn(arm_btn), .wires(wires), .key_code(key_code),
        .cd(cd), .strikes(strikes), .state_out(state_out), .defused(defused), .exploded(exploded)
    );

    always #5 clk = ~clk;

    wire [15:0] obs = {state_out, cd.switch_op, cd.sec_timer, strikes, defused, exploded};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // game-level reference: inputs reach the game two samples late, edges need the sample before
    int         m_state, m_strikes, m_count;
    logic [3:0] m_code, m_mask;
    bit         m_switch, m_tick, m_def, m_exp;
    logic       arm_h[3];
    logic [3:0] wir_h[3];

    task automatic model_reset();
        m_state = 0; m_strikes = 0; m_count = 0; m_code = 4'h0; m_mask = 4'h0;
        m_switch = 0; m_tick = 0; m_def = 0; m_exp = 0;
        for (int i = 0; i < 3; i++) begin
            arm_h[i] = 1'b0;
            wir_h[i] = 4'hF;
        end
    endtask

    task automatic model_step();
        logic       rise, boom, win, hit;
        logic [3:0] w_sync, cut;
        int         period, ns;
        rise   = arm_h[1] & ~arm_h[0];
        w_sync = wir_h[1];
        cut    = wir_h[0] & ~wir_h[1];
        arm_h[0] = arm_h[1]; arm_h[1] = arm_h[2]; arm_h[2] = arm_btn;
        wir_h[0] = wir_h[1]; wir_h[1] = wir_h[2]; wir_h[2] = wires;
        m_switch = 0;
        m_tick   = 0;
        case (m_state)
            0: if (rise && w_sync == 4'hF && key_code != 4'h0) begin
                m_code = key_code; m_mask = 4'h0; m_strikes = 0; m_switch = 1; m_state = 1;
            end
            1: begin
                m_count = 0;
                m_state = 2;
            end
            2: begin
                period = TICK_DIV >> m_strikes;
                hit    = (m_count == period - 1);
                ns     = ((cut & ~m_code) != 4'h0) ? m_strikes + 1 : m_strikes;
                if (ns > MAX_STRIKES) ns = MAX_STRIKES;
                m_mask = m_mask | (cut & m_code);
                boom   = (ns == MAX_STRIKES) ||
                         (hit && cd.digit_three == 0 && cd.digit_two == 0 && cd.digit_one == 0);
                win    = (m_mask == m_code);
                if (boom) begin
                    m_state = 4; m_exp = 1;
                end else if (win) begin
                    m_state = 3; m_def = 1;
                end else begin
                    m_tick = hit;
                end
                m_count   = hit ? 0 : ((m_count == TICK_DIV - 1) ? 0 : m_count + 1);
                m_strikes = ns;
            end
            default: if (rise && w_sync == 4'hF) begin
                m_state = 0; m_strikes = 0; m_mask = 4'h0; m_def = 0; m_exp = 0;
            end
        endcase
    endtask

    function automatic logic [15:0] expv();
        return {3'(m_state), (m_switch ? 8'h10 : 8'h00), m_tick, 2'(m_strikes), m_def, m_exp};
    endfunction

    task automatic run_cycle();
        @(posedge clk);
        if (!reset) model_reset();
        else model_step();
        #1;
        cyc++;
    endtask

    task automatic set_digits(input int three, input int two, input int one);
        cd.digit_three = 4'(three);
        cd.digit_two   = 4'(two);
        cd.digit_one   = 4'(one);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            checks++;
            if (obs !== 16'h0000) begin
                errors++;
                $display("FAIL reset_state cyc %0d: got %h want %h", cyc, obs, 16'h0000);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_arm_and_tick();
        int sw = 0;
        int last = -1;
        key_code = 4'b0011;
        set_digits($urandom_range(9, 1), $urandom_range(9, 1), $urandom_range(9, 1));
        for (int i = 0; i < 60; i++) begin
            if (i == 2) arm_btn = 1'b1;
            if (i == 4) arm_btn = 1'b0;
            run_cycle();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL arm_tick cyc %0d: got %h want %h", cyc, obs, expv());
            end
            if (cd.switch_op == 8'h10) sw++;
            if (cd.sec_timer) begin
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 8) begin
                        errors++;
                        $display("FAIL tick_period0 cyc %0d: got %0d want 8", cyc, cyc - last);
                    end
                end
                last = cyc;
            end
        end
        checks++;
        if (sw != 1) begin
            errors++;
            $display("FAIL start_pulses: got %0d want 1", sw);
        end
    endtask

    task automatic test_defuse();
        int ticks = 0;
        for (int i = 0; i < 30; i++) begin
            if (i == 1) wires[0] = 1'b0;
            if (i == 7) wires[1] = 1'b0;
            run_cycle();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL defuse cyc %0d: got %h want %h", cyc, obs, expv());
            end
            if (i >= 10 && cd.sec_timer) ticks++;
        end
        checks++;
        if ({state_out, defused, strikes, ticks} !== {3'd3, 1'b1, 2'd0, 32'd0}) begin
            errors++;
            $display("FAIL defuse_final: got state %0d defused %0b strikes %0d ticks %0d want 3 1 0 0",
                     state_out, defused, strikes, ticks);
        end
    endtask

    task automatic test_strikes();
        int last = -1;
        for (int i = 0; i < 70; i++) begin
            case (i)
                0:  wires = 4'hF;
                5:  arm_btn = 1'b1;
                7:  arm_btn = 1'b0;
                12: begin arm_btn = 1'b1; key_code = 4'b0011; end
                14: arm_btn = 1'b0;
                25: wires[2] = 1'b0;
                40: wires[3] = 1'b0;
                50: wires[2] = 1'b1;
                56: wires[2] = 1'b0;
                default: ;
            endcase
            run_cycle();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL strikes cyc %0d: got %h want %h", cyc, obs, expv());
            end
            if (cd.sec_timer) begin
                if (last >= 0 && i >= 36 && i <= 41) begin
                    checks++;
                    if (cyc - last != 4) begin
                        errors++;
                        $display("FAIL tick_period1 cyc %0d: got %0d want 4", cyc, cyc - last);
                    end
                end
                if (last >= 0 && i >= 50 && i <= 57) begin
                    checks++;
                    if (cyc - last != 2) begin
                        errors++;
                        $display("FAIL tick_period2 cyc %0d: got %0d want 2", cyc, cyc - last);
                    end
                end
                last = cyc;
            end
        end
        checks++;
        if ({state_out, exploded, strikes} !== {3'd4, 1'b1, 2'd3}) begin
            errors++;
            $display("FAIL strikes_final: got state %0d exploded %0b strikes %0d want 4 1 3",
                     state_out, exploded, strikes);
        end
    endtask

    task automatic test_timeout();
        int late_ticks = 0;
        for (int i = 0; i < 40; i++) begin
            case (i)
                0:  begin wires = 4'hF; set_digits(1, 2, 3); end
                3:  arm_btn = 1'b1;
                5:  arm_btn = 1'b0;
                10: begin arm_btn = 1'b1; key_code = 4'($urandom_range(15, 1)); end
                12: arm_btn = 1'b0;
                20: set_digits(0, 0, 0);
                default: ;
            endcase
            run_cycle();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL timeout cyc %0d: got %h want %h", cyc, obs, expv());
            end
            if (i > 20 && cd.sec_timer) late_ticks++;
        end
        checks++;
        if ({state_out, exploded, late_ticks} !== {3'd4, 1'b1, 32'd0}) begin
            errors++;
            $display("FAIL timeout_final: got state %0d exploded %0b ticks %0d want 4 1 0",
                     state_out, exploded, late_ticks);
        end
    endtask

    task automatic test_priority();
        for (int i = 0; i < 45; i++) begin
            case (i)
                0:  set_digits(4, 5, 6);
                2:  arm_btn = 1'b1;
                4:  arm_btn = 1'b0;
                8:  begin arm_btn = 1'b1; key_code = 4'b0011; end
                10: arm_btn = 1'b0;
                15: wires = 4'b1011;
                20: wires = 4'b0011;
                25: wires = 4'b0010;
                30: wires = 4'b0110;
                35: wires = 4'b0000;
                default: ;
            endcase
            run_cycle();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL priority cyc %0d: got %h want %h", cyc, obs, expv());
            end
        end
        checks++;
        if ({state_out, exploded, defused} !== {3'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL priority_final: got state %0d exploded %0b defused %0b want 4 1 0",
                     state_out, exploded, defused);
        end
    endtask

    task automatic test_arm_guards();
        int sw = 0;
        for (int i = 0; i < 32; i++) begin
            case (i)
                0:  wires = 4'hF;
                3:  arm_btn = 1'b1;
                5:  arm_btn = 1'b0;
                10: begin wires = 4'b1110; key_code = 4'b0101; arm_btn = 1'b1; end
                12: arm_btn = 1'b0;
                18: begin wires = 4'hF; key_code = 4'h0; end
                22: arm_btn = 1'b1;
                24: arm_btn = 1'b0;
                default: ;
            endcase
            run_cycle();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL arm_guard cyc %0d: got %h want %h", cyc, obs, expv());
            end
            if (i == 8) begin
                checks++;
                if (state_out !== 3'd0) begin
                    errors++;
                    $display("FAIL rearm_from_exploded: got state %0d want 0", state_out);
                end
            end
            if (cd.switch_op == 8'h10) sw++;
        end
        checks++;
        if (sw != 0 || state_out !== 3'd0) begin
            errors++;
            $display("FAIL guarded_arm: got pulses %0d state %0d want 0 0", sw, state_out);
        end
    endtask

    task automatic test_reset_mid_active();
        bit seen = 0;
        key_code = 4'b0101;
        set_digits(9, 9, 9);
        for (int i = 0; i < 40 && !seen; i++) begin
            if (i == 2) arm_btn = 1'b1;
            if (i == 4) arm_btn = 1'b0;
            run_cycle();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL pre_reset cyc %0d: got %h want %h", cyc, obs, expv());
            end
            if (i > 6 && cd.sec_timer) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_setup: got no tick within 40 cycles want one");
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (obs !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: got %h want %h", obs, 16'h0000);
        end
        model_reset();
        run_cycle();
        run_cycle();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL post_reset cyc %0d: got %h want %h", cyc, obs, expv());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(9, 0) == 0) wires[$urandom_range(3, 0)] ^= 1'b1;
            if ($urandom_range(39, 0) == 0) wires = 4'hF;
            if ($urandom_range(14, 0) == 0) arm_btn = ~arm_btn;
            if ($urandom_range(29, 0) == 0) key_code = 4'($urandom_range(15, 0));
            if ($urandom_range(24, 0) == 0) begin
                if ($urandom_range(3, 0) == 0) set_digits(0, 0, 0);
                else set_digits($urandom_range(9, 0), $urandom_range(9, 0), $urandom_range(9, 1));
            end
            run_cycle();
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL random cyc %0d: got %h want %h", cyc, obs, expv());
            end
        end
    endtask

    initial begin
        set_digits(1, 1, 1);
        model_reset();
        test_reset();
        test_arm_and_tick();
        test_defuse();
        test_strikes();
        test_timeout();
        test_priority();
        test_arm_guards();
        test_reset_mid_active();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bomb_sequencer.md
Name: bomb_sequencer

Overview:
- Game-level controller that sequences the countdown timer: arms it, generates its one-second tick, monitors the defuse wires, counts strikes and decides DEFUSED or EXPLODED.
- Sits between the board inputs (arm button, wire loop inputs, code switches) and the countdown digit datapath.
- Drives the countdown's start command and tick strobe, and reads back its three BCD digits for zero detection.

Parameters:
TICK_DIV, 50000000, clk cycles per second tick at 0 strikes (must be ≥8, power of two recommended)
MAX_STRIKES, 3, strike count that forces EXPLODED (1..3)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low; clears all state
arm_btn  in  1  debounced arm button, asynchronous to clk, active-high
wires  in  4  wire loop inputs, asynchronous; 1 = intact, 0 = cut
key_code  in  4  wires that must be cut to defuse; latched at arm
digit_three  in  4  countdown hundreds digit (BCD)
digit_two  in  4  countdown tens digit (BCD)
digit_one  in  4  countdown ones digit (BCD)
switch_op  out  8  countdown command: 8'h10 for one cycle = start, else 8'h00
sec_timer  out  1  one-cycle tick strobe to countdown
strikes  out  2  current strike count
state_out  out  3  FSM state encoding
defused  out  1  high while in DEFUSED
exploded  out  1  high while in EXPLODED

Behaviour:
- Reset (async, reset=0): state IDLE, switch_op=8'h00, sec_timer=0, strikes=0, defused=0, exploded=0, prescaler=0, code latch=0, cut mask=0. Synchronizer flops reset to arm=0 and wires=4'hF.
- Input conditioning:
  - arm_btn and wires each pass through a 2-flop synchronizer and then an edge register.
  - An arm rise is sync=1 and prev=0.
  - A cut event on bit i is prev=1 and sync=0.
  - All registered outputs respond on the 3rd rising clk edge after an input change.
- State encodings: IDLE=0, ARMING=1, ACTIVE=2, DEFUSED=3, EXPLODED=4. Values 5–7 are unreachable and recover to IDLE.
- IDLE:
  - On an arm rise with sync wires==4'hF and key_code≠0: latch key_code, clear the cut mask and strikes, drive switch_op=8'h10 for exactly one cycle, go to ARMING.
  - Otherwise the arm rise is ignored.
- ARMING: one cycle only. Clear the prescaler, then go to ACTIVE.
- ACTIVE:
  - Prescaler period is P = TICK_DIV >> strikes.
  - When the count reaches P-1, sec_timer=1 for one cycle and the count returns to 0.
  - A strike change takes effect on the next count compare; the count is not cleared. If the count already exceeds the new P-1, it wraps at TICK_DIV-1 once.
  - Cut on a latched code bit: set that bit in the cut mask.
  - Cut on any non-code bit: strikes += 1 per cycle, regardless of how many wrong bits were cut in that cycle. strikes saturates at MAX_STRIKES.
  - Re-cutting a wire or re-joining one (0→1) has no effect.
  - Explode condition: strikes reaches MAX_STRIKES, OR sec_timer fires in a cycle where all three digits are 0.
  - Defuse condition: cut mask == latched code.
  - Same-cycle priority: EXPLODED > DEFUSED > tick.
  - When either condition triggers, sec_timer is suppressed that cycle.
- DEFUSED / EXPLODED:
  - Terminal states. No ticks, switch_op=8'h00, so the countdown digits freeze.
  - defused or exploded is held high.
  - strikes holds its value.
  - An arm rise with sync wires==4'hF returns the block to IDLE, clearing defused/exploded, strikes and the mask.
- switch_op is never 8'h10 for two consecutive cycles, and is never asserted outside the IDLE→ARMING transition.
- Reset asserted mid-operation: outputs clear immediately (asynchronously), and any in-flight switch_op or sec_timer pulse is truncated.

Test Plan (TICK_DIV=8, MAX_STRIKES=3):
1. Arm and tick: reset, wires=F, key_code=4'b0011, pulse arm_btn → one switch_op=8'h10 pulse, then state ARMING, then ACTIVE. sec_timer pulses every 8 cycles while digits are nonzero.
2. Defuse: in ACTIVE, cut wire0 then wire1 → after the 2nd cut, state=DEFUSED, defused=1, no further sec_timer; strikes=0.
3. Strikes: cut wire2 → strikes=1 and tick period becomes 4. Cut wire3 → strikes=2, period 2. Re-join and re-cut wire2 → strikes=3, EXPLODED, exploded=1.
4. Timeout: hold digits at 0/0/0 in ACTIVE → on the next tick compare, sec_timer stays 0, state=EXPLODED.
5. Priority: in one cycle, cut the final code wire plus a non-code wire with strikes=2 → EXPLODED, not DEFUSED.
6. Arm guards and reset: arm with wires=4'b1110 or key_code=0 → stays IDLE, no switch_op. Assert reset mid-ACTIVE → all outputs 0 and state IDLE within the same cycle. From EXPLODED, arm with wires=F → IDLE.
